// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared CPU word type and memory-arbiter state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IACC  = 3'd1,
        DACC  = 3'd2,
        IRESP = 3'd3,
        DRESP = 3'd4
    } arb_state_t;

    // Wide enough for any TIMEOUT up to 255
    localparam int unsigned ARB_CNT_W = 8;

endpackage : cpu_types_pkg

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module : mem_arbiter_if
// Brief  : CPU-side request/response and RAM-side strobe bundle of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  ihit;
    logic  dhit;
    word_t iload;
    word_t dload;
    logic  bus_err;
    logic  ram_ren;
    logic  ram_wen;
    word_t ram_addr;
    word_t ram_wdata;
    word_t ram_rdata;
    logic  ram_ready;

    // Arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
        output ihit, dhit, iload, dload, bus_err,
               ram_ren, ram_wen, ram_addr, ram_wdata
    );

    // Requester / RAM view
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
        input  ihit, dhit, iload, dload, bus_err,
               ram_ren, ram_wen, ram_addr, ram_wdata
    );

endinterface : mem_arbiter_if

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Single-port RAM arbiter between instruction fetch and data access,
//          data first, with a bounded wait that aborts into a bus error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  wire logic    CLK,
    input  wire logic    nRST,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_IACC  = IACC;
    localparam logic [2:0] S_DACC  = DACC;
    localparam logic [2:0] S_IRESP = IRESP;
    localparam logic [2:0] S_DRESP = DRESP;

    localparam logic [ARB_CNT_W-1:0] c_TMO_LAST = ARB_CNT_W'(TIMEOUT - 1);

    logic [2:0]           r_state;
    logic [ARB_CNT_W-1:0] r_cnt;
    logic                 r_err;
    logic                 r_write;
    word_t                r_addr;
    word_t                r_wdata;
    word_t                r_iload;
    word_t                r_dload;

    logic w_in_acc;
    logic w_in_resp;
    logic w_data_req;
    logic w_expire;

    assign w_data_req = bus.dREN | bus.dWEN;
    assign w_in_acc   = (r_state == S_IACC) | (r_state == S_DACC);
    assign w_in_resp  = (r_state == S_IRESP) | (r_state == S_DRESP);
    // ram_ready wins over expiry when both land on the final wait cycle
    assign w_expire   = ~bus.ram_ready & (r_cnt == c_TMO_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_data_req) begin
                        r_state <= S_DACC;
                        r_addr  <= bus.daddr;
                        r_wdata <= bus.dstore;
                        r_write <= bus.dWEN;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end else if (bus.iREN) begin
                        r_state <= S_IACC;
                        r_addr  <= bus.iaddr;
                        r_write <= 1'b0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end

                S_IACC: begin
                    if (bus.ram_ready) begin
                        r_state <= S_IRESP;
                        r_iload <= bus.ram_rdata;
                    end else if (w_expire) begin
                        r_state <= S_IRESP;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DACC: begin
                    if (bus.ram_ready) begin
                        r_state <= S_DRESP;
                        if (!r_write) begin
                            r_dload <= bus.ram_rdata;
                        end
                    end else if (w_expire) begin
                        r_state <= S_DRESP;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Response states ignore requests so a late-dropped strobe
                // cannot start a second access
                S_IRESP, S_DRESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ihit      = (r_state == S_IRESP);
    assign bus.dhit      = (r_state == S_DRESP);
    assign bus.bus_err   = w_in_resp & r_err;
    assign bus.iload     = r_iload;
    assign bus.dload     = r_dload;
    assign bus.ram_ren   = w_in_acc & ~r_write;
    assign bus.ram_wen   = w_in_acc &  r_write;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Scoreboard bench for mem_arbiter with a behavioural RAM and model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TMO = 4;

    typedef struct {
        bit    is_d;
        bit    err;
        word_t iload;
        word_t dload;
    } exp_t;

    typedef struct {
        int    delay;
        word_t addr;
        bit    wr;
        word_t wdata;
    } acc_t;

    logic CLK;
    logic nRST;
    mem_arbiter_if bif();

    mem_arbiter #(.TIMEOUT(TMO)) u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  exp_q[$];
    acc_t  desc_q[$];
    word_t ram_mem[word_t];
    word_t model_mem[word_t];
    word_t exp_iload = '0;
    word_t exp_dload = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic word_t init_word(input word_t a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic word_t model_rd(input word_t a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    function automatic word_t ram_rd(input word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
    endfunction

    // Cycles from request edge to the hit: first ACC cycle, d waits, response
    function automatic int lat(input int d);
        return ((d < TMO) ? d : TMO - 1) + 2;
    endfunction

    // Behavioural RAM: ready arrives in the delay-th cycle of a strobe run;
    // outside a run ready/rdata are random noise
    bit   rsp_active = 0;
    int   rsp_k      = 0;
    acc_t rsp_cur;
    always @(negedge CLK) begin
        if (nRST && (bif.ram_ren || bif.ram_wen)) begin
            if (!rsp_active) begin
                rsp_active = 1;
                rsp_k      = 0;
                if (desc_q.size() == 0) begin
                    chk("unexpected_ram_access", 32'd1, 32'd0);
                    rsp_cur.delay = 0;
                    rsp_cur.wr    = bif.ram_wen;
                end else begin
                    rsp_cur = desc_q.pop_front();
                    chk("ram_addr", bif.ram_addr, rsp_cur.addr);
                    chk("ram_wen", {31'd0, bif.ram_wen}, {31'd0, rsp_cur.wr});
                    chk("ram_ren", {31'd0, bif.ram_ren}, {31'd0, ~rsp_cur.wr});
                    if (rsp_cur.wr) chk("ram_wdata", bif.ram_wdata, rsp_cur.wdata);
                end
            end else begin
                rsp_k++;
            end
            if (rsp_k == rsp_cur.delay) begin
                bif.ram_ready = 1'b1;
                if (rsp_cur.wr) begin
                    ram_mem[bif.ram_addr] = bif.ram_wdata;
                    bif.ram_rdata = $urandom;
                end else begin
                    bif.ram_rdata = ram_rd(bif.ram_addr);
                end
            end else begin
                bif.ram_ready = 1'b0;
                bif.ram_rdata = $urandom;
            end
        end else begin
            rsp_active    = 0;
            bif.ram_ready = 1'($urandom_range(0, 1));
            bif.ram_rdata = $urandom;
        end
    end

    // Monitor: every hit pops one scoreboard entry
    always @(negedge CLK) begin
        if (nRST) begin
            if (bif.ihit && bif.dhit) begin
                chk("hit_overlap", 32'd1, 32'd0);
            end else if (bif.ihit || bif.dhit) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_hit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("hit_kind_is_d", {31'd0, bif.dhit}, {31'd0, e.is_d});
                    chk("bus_err", {31'd0, bif.bus_err}, {31'd0, e.err});
                    chk("iload", bif.iload, e.iload);
                    chk("dload", bif.dload, e.dload);
                    chk("strobes_in_resp", {30'd0, bif.ram_ren, bif.ram_wen}, 32'd0);
                end
            end else if (bif.bus_err) begin
                chk("bus_err_without_hit", 32'd1, 32'd0);
            end
        end
    end

    task automatic push_data(input bit wr, input word_t a, input word_t d, input int dly);
        acc_t ac;
        exp_t e;
        ac.delay = dly; ac.addr = a; ac.wr = wr; ac.wdata = d;
        desc_q.push_back(ac);
        e.err = (dly >= TMO);
        if (!e.err) begin
            if (wr) model_mem[a] = d;
            else    exp_dload = model_rd(a);
        end
        e.is_d = 1; e.iload = exp_iload; e.dload = exp_dload;
        exp_q.push_back(e);
    endtask

    task automatic push_fetch(input word_t a, input int dly);
        acc_t ac;
        exp_t e;
        ac.delay = dly; ac.addr = a; ac.wr = 0; ac.wdata = '0;
        desc_q.push_back(ac);
        e.err = (dly >= TMO);
        if (!e.err) exp_iload = model_rd(a);
        e.is_d = 0; e.iload = exp_iload; e.dload = exp_dload;
        exp_q.push_back(e);
    endtask

    // Called on a negedge with the arbiter idle
    task automatic do_txn(input bit ie, input bit dr, input bit dw,
                          input word_t ia, input word_t da, input word_t ds,
                          input int di, input int dd, input bit drop);
        bit de;
        bit got_i;
        bit got_d;
        int it;
        int d_at;
        int i_at;
        de    = dr | dw;
        got_i = ~ie;
        got_d = ~de;
        d_at  = lat(dd);
        i_at  = de ? lat(dd) + 1 + lat(di) : lat(di);
        if (de) push_data(dw, da, ds, dd);
        if (ie) push_fetch(ia, di);
        bif.iREN = ie; bif.iaddr = ia;
        bif.dREN = dr; bif.dWEN = dw; bif.daddr = da; bif.dstore = ds;
        it = 0;
        while (!(got_i && got_d) && it < 40) begin
            @(negedge CLK);
            it++;
            if (it == 1) begin
                // Already-latched operands change under the access
                bif.daddr  = $urandom;
                bif.dstore = $urandom;
                if (ie && !de) bif.iaddr = $urandom;
                if (drop && de && !ie) begin bif.dREN = 0; bif.dWEN = 0; end
                if (drop && ie && !de) bif.iREN = 0;
            end
            if (bif.dhit && de && !got_d) begin
                chk("latency_d", it, d_at);
                got_d = 1; bif.dREN = 0; bif.dWEN = 0;
            end
            if (bif.ihit && ie && !got_i) begin
                chk("latency_i", it, i_at);
                got_i = 1; bif.iREN = 0;
            end
        end
        if (!(got_i && got_d)) chk("hit_timeout", 32'd0, 32'd1);
        bif.iREN = 0; bif.dREN = 0; bif.dWEN = 0;
        @(negedge CLK);
    endtask

    function automatic int pick_delay();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3))
                                          : int'($urandom_range(4, 6));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        bif.iREN = 0; bif.iaddr = '0; bif.dREN = 0; bif.dWEN = 0;
        bif.daddr = '0; bif.dstore = '0;
        repeat (3) @(negedge CLK);
        chk("rst_hits", {29'd0, bif.ihit, bif.dhit, bif.bus_err}, 32'd0);
        chk("rst_strobes", {30'd0, bif.ram_ren, bif.ram_wen}, 32'd0);
        chk("rst_iload", bif.iload, 32'd0);
        chk("rst_dload", bif.dload, 32'd0);
        chk("rst_ram_addr", bif.ram_addr, 32'd0);
        chk("rst_ram_wdata", bif.ram_wdata, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        ram_mem[32'h100] = 32'h8C220004;
        model_mem[32'h100] = 32'h8C220004;
        do_txn(1, 0, 0, 32'h100, '0, '0, 2, 0, 0);                      // fetch
        do_txn(1, 1, 0, 32'h104, 32'h200, '0, 1, 1, 0);                 // simultaneous
        do_txn(0, 0, 1, '0, 32'h300, 32'hDEADBEEF, 0, 2, 0);            // write
        do_txn(0, 1, 0, '0, 32'h300, '0, 0, 0, 0);                      // read-back
        do_txn(0, 1, 0, '0, 32'h304, '0, 0, 20, 0);                     // timeout
        do_txn(1, 0, 0, 32'h308, '0, '0, 9, 0, 0);                      // fetch timeout
        do_txn(0, 1, 1, '0, 32'h30C, 32'h12345678, 0, 0, 0);            // both -> write
        do_txn(1, 0, 0, 32'h30C, '0, '0, 3, 0, 1);                      // dropped fetch

        for (int n = 0; n < 150; n++) begin
            int    kind;
            bit    ie, dr, dw, drop;
            word_t ia, da;
            kind = int'($urandom_range(0, 2));
            ie   = (kind != 1);
            dw   = (kind != 0) && ($urandom_range(0, 2) == 0);
            dr   = (kind != 0) && (!dw || $urandom_range(0, 1) == 1);
            drop = (kind != 2) && ($urandom_range(0, 3) == 0);
            ia   = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            da   = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            do_txn(ie, dr, dw, ia, da, $urandom, pick_delay(), pick_delay(), drop);
        end

        // Asynchronous reset in the middle of a data access
        bif.dREN = 1; bif.daddr = 32'h500;
        begin
            acc_t ac;
            ac.delay = 50; ac.addr = 32'h500; ac.wr = 0; ac.wdata = '0;
            desc_q.push_back(ac);
        end
        @(negedge CLK);
        @(negedge CLK);
        #1 nRST = 1'b0;
        #1;
        chk("arst_strobes", {30'd0, bif.ram_ren, bif.ram_wen}, 32'd0);
        chk("arst_hits", {29'd0, bif.ihit, bif.dhit, bif.bus_err}, 32'd0);
        chk("arst_iload", bif.iload, 32'd0);
        chk("arst_dload", bif.dload, 32'd0);
        chk("arst_ram_addr", bif.ram_addr, 32'd0);
        chk("arst_ram_wdata", bif.ram_wdata, 32'd0);
        chk("arst_access_started", desc_q.size(), 32'd0);
        exp_q.delete();
        exp_iload = '0;
        exp_dload = '0;
        bif.dREN = 0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (10) @(negedge CLK);
        do_txn(1, 0, 0, 32'h100, '0, '0, 1, 0, 0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("ram_queue_drained", desc_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire
